// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/handshake inputs to the sequencer and the
// latch enable/flush, status and stall-count outputs from it.
//   slave  : the sequencer side (inputs ihit..wb_halt, outputs pc_en..stall_cnt)
//   master : the pipeline/datapath side (drives inputs, observes outputs)
interface pipeline_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             mem_dreq;
  logic             mem_redirect;
  logic             idex_memread;
  logic [REG_W-1:0] idex_wsel;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             wb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  ihit, dhit, mem_dreq, mem_redirect, idex_memread, idex_wsel, ifid_rs, ifid_rt,
           wb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
           halted, err, stall_cnt
  );

  modport master (
    output ihit, dhit, mem_dreq, mem_redirect, idex_memread, idex_wsel, ifid_rs, ifid_rt,
           wb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
           halted, err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : pipeline_ctrl_if.slave -- memory handshakes, load-use operands, MEM
//          redirect and halt in; PC/latch enables and flushes, halted, err and
//          the saturating stall-cycle counter out.
// Enables/flushes are combinational from state and inputs; halted, err and
// stall_cnt come straight from registers.
module pipeline_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input logic            CLK,
  input logic            RST,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDwait = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic dwait, load_use;

  assign dwait    = bus.mem_dreq & ~bus.dhit;
  assign load_use = bus.idex_memread & (bus.idex_wsel != '0) &
                    ((bus.idex_wsel == bus.ifid_rs) | (bus.idex_wsel == bus.ifid_rt));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      // A dhit cycle in DWAIT is evaluated exactly like RUN, so a redirect
      // held in the frozen EX/MEM latch takes effect on that cycle.
      StRun, StDwait: begin
        if (bus.wb_halt) begin
          state_d = StHalt;
        end else if (dwait) begin
          if (wait_cnt_q == WaitLast) begin
            state_d = StErr;
          end else begin
            state_d    = StDwait;
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else if (bus.mem_redirect) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_en     = 1'b1;
          idex_flush  = 1'b1;
          exmem_en    = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
          state_d     = StRun;
        end else if (load_use || !bus.ihit) begin
          // Hold PC and IF/ID, inject one bubble into ID/EX, let the rest drain.
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          state_d    = StRun;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          state_d  = StRun;
        end

        if (!pc_en && (stall_cnt_q != '1)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      StHalt, StErr: state_d = state_q;
      default:       state_d = StRun;
    endcase

    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_en    = memwb_en;
  assign bus.halted      = (state_q == StHalt);
  assign bus.err         = (state_q == StErr);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
